// File: rtl/dct8_chen_stream.sv
// dct8_chen_stream: 8-point forward DCT-II (Chen factorisation) with a 4-stage
// ready/valid pipeline, round-half-away-from-zero output and saturation.
// Optional build macro: DCT_SAT_STATUS_EN adds sat_flag / sat_count outputs.
module dct8_chen_stream #(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned CONST_W = 16,  // must stay <= 31
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*IN_W-1:0]  in_data,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*OUT_W-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag
`ifdef DCT_SAT_STATUS_EN
    ,
    output logic               sat_flag,
    output logic [15:0]        sat_count
`endif
);

    // Fractional bits of the cosine constants
    localparam int FRAC  = int'(CONST_W) - 2;
    // Butterfly width: x0+..+x7 needs three extra bits
    localparam int BF_W  = int'(IN_W) + 3;
    // Accumulator width, comfortably above the worst-case sum of four products
    localparam int ACC_W = int'(IN_W) + int'(CONST_W) + 4;
    // Constants below are cos(k*pi/16) scaled by 2^30; QSH rescales to FRAC bits
    localparam int QSH   = 30 - FRAC;
    // Result carries FRAC fractional bits plus the 1/2 DCT normalisation
    localparam int RSH   = FRAC + 1;

    function automatic logic signed [CONST_W-1:0] qconst(input longint c30);
        longint r;
        r = (c30 + (longint'(1) <<< (QSH - 1))) >>> QSH;
        return r[CONST_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] mul(input logic signed [BF_W-1:0]    a,
                                                     input logic signed [CONST_W-1:0] k);
        return ACC_W'(a) * ACC_W'(k);
    endfunction

    localparam logic signed [CONST_W-1:0] K1 = qconst(64'sd1053110175);
    localparam logic signed [CONST_W-1:0] K2 = qconst(64'sd992008094);
    localparam logic signed [CONST_W-1:0] K3 = qconst(64'sd892783698);
    localparam logic signed [CONST_W-1:0] K4 = qconst(64'sd759250125);
    localparam logic signed [CONST_W-1:0] K5 = qconst(64'sd596538995);
    localparam logic signed [CONST_W-1:0] K6 = qconst(64'sd410903207);
    localparam logic signed [CONST_W-1:0] K7 = qconst(64'sd209476638);

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< FRAC;
    localparam logic signed [ACC_W-1:0] OMAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OMIN = -(ACC_W'(1) <<< (OUT_W - 1));

    // Pipeline control
    logic advance;
    logic s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q, out_tag_q;

    // Stage data
    logic signed [IN_W-1:0]  x_c [8];
    logic signed [BF_W-1:0]  b_c [4];
    logic signed [BF_W-1:0]  e2_c, e3_c, f0_c, f1_c;
    logic signed [BF_W-1:0]  s1_b_q [4];
    logic signed [BF_W-1:0]  s1_e2_q, s1_e3_q, s1_f0_q, s1_f1_q;
    logic signed [ACC_W-1:0] prod_c [22];
    logic signed [ACC_W-1:0] s2_p_q [22];
    logic signed [ACC_W-1:0] acc_c [8];
    logic signed [ACC_W-1:0] s3_acc_q [8];
    logic [8*OUT_W-1:0]      y_c;
    logic [8*OUT_W-1:0]      out_data_q;
`ifdef DCT_SAT_STATUS_EN
    logic [7:0]  sat_c;
    logic        sat_flag_q;
    logic [15:0] sat_count_q;
`endif

    // A full output register that is not being drained freezes every stage
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // S1 combinational: outer butterfly, then the even-half second and third butterflies
    always_comb begin
        logic signed [BF_W-1:0] a0, a1, a2, a3, e0, e1;
        for (int i = 0; i < 8; i++) begin
            x_c[i] = in_data[i*IN_W +: IN_W];
        end
        for (int i = 0; i < 4; i++) begin
            b_c[i] = BF_W'(x_c[i]) - BF_W'(x_c[7-i]);
        end
        a0   = BF_W'(x_c[0]) + BF_W'(x_c[7]);
        a1   = BF_W'(x_c[1]) + BF_W'(x_c[6]);
        a2   = BF_W'(x_c[2]) + BF_W'(x_c[5]);
        a3   = BF_W'(x_c[3]) + BF_W'(x_c[4]);
        e0   = a0 + a3;
        e1   = a1 + a2;
        e2_c = a0 - a3;
        e3_c = a1 - a2;
        f0_c = e0 + e1;
        f1_c = e0 - e1;
    end

    // S1 register: loads only for a real vector so idle inputs never enter the pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            for (int i = 0; i < 4; i++) s1_b_q[i] <= '0;
            s1_e2_q    <= '0;
            s1_e3_q    <= '0;
            s1_f0_q    <= '0;
            s1_f1_q    <= '0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_tag_q <= in_tag;
                for (int i = 0; i < 4; i++) s1_b_q[i] <= b_c[i];
                s1_e2_q  <= e2_c;
                s1_e3_q  <= e3_c;
                s1_f0_q  <= f0_c;
                s1_f1_q  <= f1_c;
            end
        end
    end

    // S2 combinational: every constant multiply of the factorisation
    always_comb begin
        prod_c[0]  = mul(s1_f0_q, K4);    // X0
        prod_c[1]  = mul(s1_f1_q, K4);    // X4
        prod_c[2]  = mul(s1_e2_q, K2);    // X2
        prod_c[3]  = mul(s1_e3_q, K6);
        prod_c[4]  = mul(s1_e2_q, K6);    // X6
        prod_c[5]  = mul(s1_e3_q, K2);
        prod_c[6]  = mul(s1_b_q[0], K1);  // X1
        prod_c[7]  = mul(s1_b_q[1], K3);
        prod_c[8]  = mul(s1_b_q[2], K5);
        prod_c[9]  = mul(s1_b_q[3], K7);
        prod_c[10] = mul(s1_b_q[0], K3);  // X3
        prod_c[11] = mul(s1_b_q[1], K7);
        prod_c[12] = mul(s1_b_q[2], K1);
        prod_c[13] = mul(s1_b_q[3], K5);
        prod_c[14] = mul(s1_b_q[0], K5);  // X5
        prod_c[15] = mul(s1_b_q[1], K1);
        prod_c[16] = mul(s1_b_q[2], K7);
        prod_c[17] = mul(s1_b_q[3], K3);
        prod_c[18] = mul(s1_b_q[0], K7);  // X7
        prod_c[19] = mul(s1_b_q[1], K5);
        prod_c[20] = mul(s1_b_q[2], K3);
        prod_c[21] = mul(s1_b_q[3], K1);
    end

    // S2 register: products, loaded when a valid S1 vector moves forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            for (int i = 0; i < 22; i++) s2_p_q[i] <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_tag_q <= s1_tag_q;
                for (int i = 0; i < 22; i++) s2_p_q[i] <= prod_c[i];
            end
        end
    end

    // S3 combinational: signed accumulation of products per coefficient
    always_comb begin
        acc_c[0] = s2_p_q[0];
        acc_c[4] = s2_p_q[1];
        acc_c[2] = s2_p_q[2] + s2_p_q[3];
        acc_c[6] = s2_p_q[4] - s2_p_q[5];
        acc_c[1] = s2_p_q[6] + s2_p_q[7] + s2_p_q[8] + s2_p_q[9];
        acc_c[3] = s2_p_q[10] - s2_p_q[11] - s2_p_q[12] - s2_p_q[13];
        acc_c[5] = s2_p_q[14] - s2_p_q[15] + s2_p_q[16] + s2_p_q[17];
        acc_c[7] = s2_p_q[18] - s2_p_q[19] + s2_p_q[20] - s2_p_q[21];
    end

    // S3 register: accumulated sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            s3_tag_q   <= '0;
            for (int i = 0; i < 8; i++) s3_acc_q[i] <= '0;
        end else if (advance) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_tag_q <= s2_tag_q;
                for (int i = 0; i < 8; i++) s3_acc_q[i] <= acc_c[i];
            end
        end
    end

    // S4 combinational: round magnitude half-up (i.e. away from zero), then clip
    always_comb begin
        logic signed [ACC_W-1:0] mag, rnd, rq;
        y_c = '0;
`ifdef DCT_SAT_STATUS_EN
        sat_c = '0;
`endif
        for (int k = 0; k < 8; k++) begin
            mag = s3_acc_q[k][ACC_W-1] ? -s3_acc_q[k] : s3_acc_q[k];
            rnd = (mag + HALF) >>> RSH;
            rq  = s3_acc_q[k][ACC_W-1] ? -rnd : rnd;
            if (rq > OMAX) begin
                y_c[k*OUT_W +: OUT_W] = OMAX[OUT_W-1:0];
`ifdef DCT_SAT_STATUS_EN
                sat_c[k] = 1'b1;
`endif
            end else if (rq < OMIN) begin
                y_c[k*OUT_W +: OUT_W] = OMIN[OUT_W-1:0];
`ifdef DCT_SAT_STATUS_EN
                sat_c[k] = 1'b1;
`endif
            end else begin
                y_c[k*OUT_W +: OUT_W] = rq[OUT_W-1:0];
            end
        end
    end

    // S4 register: output holding register; stays put while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
        end else if (advance) begin
            out_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                out_tag_q  <= s3_tag_q;
                out_data_q <= y_c;
            end
        end
    end

`ifdef DCT_SAT_STATUS_EN
    // Saturation flag travels with the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_q <= 1'b0;
        end else if (advance) begin
            if (s3_valid_q) begin
                sat_flag_q <= |sat_c;
            end else begin
                sat_flag_q <= 1'b0;
            end
        end
    end

    // Count delivered vectors that clipped; the 16-bit counter wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_q <= '0;
        end else if (out_valid_q && out_ready && sat_flag_q) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_count_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_dct8_chen_stream.sv
// Self-checking bench for dct8_chen_stream: real-valued DCT model with a
// scoreboard, plus directed vectors with hand-computed coefficients.
module tb_dct8_chen_stream;

    localparam real PI = 3.14159265358979323846;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [127:0] in_data   = '0;
    logic [3:0]   in_tag    = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic [3:0]   out_tag;
`ifdef DCT_SAT_STATUS_EN
    logic         sat_flag;
    logic [15:0]  sat_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dct8_chen_stream #(
        .IN_W    (16),
        .OUT_W   (16),
        .CONST_W (16),
        .TAG_W   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef DCT_SAT_STATUS_EN
        ,
        .sat_flag  (sat_flag),
        .sat_count (sat_count)
`endif
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Ideal X[k] rounded half away from zero, before saturation
    function automatic int model_round(input logic [127:0] d, input int k);
        real acc, r;
        int  sv;
        acc = 0.0;
        for (int n = 0; n < 8; n++) begin
            sv  = int'($signed(d[n*16 +: 16]));
            acc = acc + real'(sv) * $cos(real'((2 * n + 1) * k) * PI / 16.0);
        end
        r = (k == 0) ? acc / (2.0 * $sqrt(2.0)) : acc / 2.0;
        if (r >= 0.0) return $rtoi($floor(r + 0.5));
        return -$rtoi($floor(-r + 0.5));
    endfunction

    function automatic int model_coef(input logic [127:0] d, input int k);
        int q;
        q = model_round(d, k);
        if (q > 32767) return 32767;
        if (q < -32768) return -32768;
        return q;
    endfunction

    function automatic bit model_sat(input logic [127:0] d);
        int q;
        for (int k = 0; k < 8; k++) begin
            q = model_round(d, k);
            if (q > 32767 || q < -32768) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [127:0] mk_vec(input int v);
        logic [127:0] d;
        int s;
        for (int n = 0; n < 8; n++) begin
            s = ((v * 37 + n * 113 + 11) % 1601) - 800;
            d[n*16 +: 16] = s[15:0];
        end
        return d;
    endfunction

    // Scoreboard: 8 expected coefficients per accepted vector
    int         exp_q [$];
    logic [3:0] tag_q [$];
    bit         sat_q [$];
    bit         prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [3:0]   prev_tag;
    int         out_cnt = 0;

    // Compare process, sampled mid-cycle when inputs and outputs are settled
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            tag_q.delete();
            sat_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready rule", longint'(in_ready), longint'(!out_valid || out_ready));
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_tag !== prev_tag) begin
                    errors++;
                    $display("FAIL stall hold: valid=%b tag=%0d data=%h, held tag=%0d data=%h",
                             out_valid, out_tag, out_data, prev_tag, prev_data);
                end
            end
            if (out_valid) begin
                checks++;
                if (tag_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious output: tag=%0d data=%h, expected no output",
                             out_tag, out_data);
                end else if (out_ready) begin
                    int  e, a;
                    bit  bad;
                    logic [3:0] et;
                    bad = 1'b0;
                    for (int k = 0; k < 8; k++) begin
                        e = exp_q.pop_front();
                        a = int'($signed(out_data[k*16 +: 16]));
                        if (a - e > 1 || e - a > 1) begin
                            bad = 1'b1;
                            $display("FAIL output %0d X%0d: got %0d, expected %0d (+-1)",
                                     out_cnt, k, a, e);
                        end
                    end
                    et = tag_q.pop_front();
                    if (out_tag !== et) begin
                        bad = 1'b1;
                        $display("FAIL output %0d tag: got %0d, expected %0d", out_cnt, out_tag, et);
                    end
                    if (bad) errors++;
`ifdef DCT_SAT_STATUS_EN
                    chk("sat_flag", longint'(sat_flag), longint'(sat_q.pop_front()));
`else
                    void'(sat_q.pop_front());
`endif
                    out_cnt++;
                end
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(model_coef(in_data, k));
                tag_q.push_back(in_tag);
                sat_q.push_back(model_sat(in_data));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end
    end

    // One vector into an empty pipe with out_ready=1; pins literal coefficients and latency
    task automatic single(input string name, input logic [127:0] d, input logic [3:0] t,
                          input logic [127:0] lit, input int tol);
        int a, e;
        in_data  = d;
        in_tag   = t;
        in_valid = 1'b1;
        @(negedge clk);
        chk({name, " in_ready"}, longint'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c < 4) begin
                chk({name, " early out_valid"}, longint'(out_valid), 0);
            end else begin
                chk({name, " out_valid"}, longint'(out_valid), 1);
                chk({name, " tag"}, longint'(out_tag), longint'(t));
                for (int k = 0; k < 8; k++) begin
                    a = int'($signed(out_data[k*16 +: 16]));
                    e = int'($signed(lit[k*16 +: 16]));
                    checks++;
                    if (a - e > tol || e - a > tol) begin
                        errors++;
                        $display("FAIL %s X%0d: got %0d, expected %0d (+-%0d)", name, k, a, e, tol);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    bit bp_done = 1'b0;

    initial begin
        int w;
        bit acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset out_data", longint'(out_data != 128'd0), 0);
        chk("reset out_tag", longint'(out_tag), 0);
        chk("reset in_ready", longint'(in_ready), 1);
`ifdef DCT_SAT_STATUS_EN
        chk("reset sat_count", longint'(sat_count), 0);
`endif
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DC 100 -> X0 = 800/(2*sqrt2) = 282.84 -> 283
        single("dc", {8{16'd100}}, 4'd3, {112'd0, 16'd283}, 0);
        // Impulse 64 at x0 -> X0=64/(2*sqrt2), Xk=32*cos(k*pi/16)
        single("impulse", {112'd0, 16'd64}, 4'd5,
               {16'd6, 16'd12, 16'd18, 16'd23, 16'd27, 16'd30, 16'd31, 16'd23}, 1);
        // Saturation at both rails
        single("sat pos", {8{16'h7FFF}}, 4'd6, {112'd0, 16'h7FFF}, 0);
        single("sat neg", {8{16'h8000}}, 4'd7, {112'd0, 16'h8000}, 0);
`ifdef DCT_SAT_STATUS_EN
        @(negedge clk);
        chk("sat_count after two clipped", longint'(sat_count), 2);
        @(posedge clk);
        #1;
`endif

        // Back-pressure: 20 vectors, random out_ready
        fork
            begin
                for (int v = 0; v < 20; v++) begin
                    in_data  = mk_vec(v);
                    in_tag   = v[3:0];
                    in_valid = 1'b1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                        w++;
                    end while (!acc && w < 200);
                    if (!acc) chk("bp accept timeout", 0, 1);
                end
                in_valid = 1'b0;
                bp_done  = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 1) == 1);
                end
                out_ready = 1'b1;
            end
        join
        w = 0;
        while (tag_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        chk("bp drain pending", tag_q.size(), 0);
        chk("bp outputs seen", out_cnt, 24);
        @(posedge clk);
        #1;

        // Full throughput: 16 back-to-back vectors
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                in_data  = mk_vec(c + 50);
                in_tag   = c[3:0];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 16) chk("thru in_ready", longint'(in_ready), 1);
            chk("thru out_valid", longint'(out_valid), longint'(c >= 4 && c < 20));
            @(posedge clk);
            #1;
        end

        // Reset with one vector on the output and three in flight
        for (int c = 0; c < 4; c++) begin
            in_data  = mk_vec(c + 90);
            in_tag   = 4'(c + 10);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset out_valid", longint'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", longint'(out_valid), 0);
        chk("async reset out_data", longint'(out_data != 128'd0), 0);
        chk("async reset in_ready", longint'(in_ready), 1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // DC -50 -> X0 = -400/(2*sqrt2) = -141.42 -> -141
        single("post-reset dc", {8{16'hFFCE}}, 4'd9, {112'd0, 16'hFF73}, 0);
        single("post-reset impulse", {112'd0, 16'd64}, 4'd1,
               {16'd6, 16'd12, 16'd18, 16'd23, 16'd27, 16'd30, 16'd31, 16'd23}, 1);
        @(negedge clk);
        chk("final scoreboard empty", tag_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dct8_chen_stream.md
Name: dct8_chen_stream

Overview:
- Parametrised, fully back-pressured 8-point forward DCT-II engine using the Chen butterfly factorisation.
- Next-generation replacement for the fixed-width DCT8 core plus wrapper. Adds real ready/valid flow control on both sides, a configurable output width with rounding and saturation, and a pass-through sideband tag.
- Sits between the row/column buffering logic and the quantiser in the image-compression datapath.

Parameters:
- IN_W, 16, signed input sample width.
- OUT_W, 16, signed output coefficient width after rounding and saturation.
- CONST_W, 16, signed cosine-constant width; constants carry CONST_W-2 fractional bits.
- TAG_W, 4, sideband tag width, passed through unchanged.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  engine accepts a vector this cycle.
- in_data  in  8*IN_W  samples x0..x7; x0 in the LSBs, each signed two's complement.
- in_tag  in  TAG_W  sideband tag captured with the vector.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_data  out  8*OUT_W  coefficients X0..X7; X0 in the LSBs.
- out_tag  out  TAG_W  tag of the vector currently on out_data.

Behaviour:
- Transform: X[k] = c(k)/2 * sum over n=0..7 of x[n]*cos((2n+1)k*pi/16), with c(0)=1/sqrt2 and c(k>0)=1.
- Rounding: round half away from zero to an integer, then saturate to the signed OUT_W range.
- Accuracy: result within ±1 LSB of the ideal real-valued value before saturation.
- Internal width: no internal overflow for any input. Intermediate width is at least IN_W+CONST_W+3.
- Pipeline, 4 register stages:
  - S1: butterfly sums and differences (x[n]±x[7-n]) plus even-part second butterfly.
  - S2: constant multiplies.
  - S3: product accumulation.
  - S4: round and saturate into the output register.
- Latency: 4 cycles from an accepted input (in_valid && in_ready at edge t) to out_valid high after edge t+4, when there is no stall.
- Throughput: one vector per cycle.
- Stall rule: advance = !out_valid || out_ready.
  - All stages shift only when advance=1.
  - in_ready = advance, combinational. No combinational path from in_valid to in_ready.
- Bubbles: each stage carries a valid bit; empty stages propagate as bubbles. A stalled S4 freezes the whole pipe.
- Output holding: while out_valid=1 && out_ready=0, out_data and out_tag stay stable and out_valid stays 1.
- Tag: follows its vector exactly through every stall.
- Reset (rst_n low, asynchronous):
  - All stage valid bits, out_valid, out_data and out_tag clear to 0.
  - in_ready reads 1 once out_valid=0.
  - Any vectors in flight are discarded.
- Reset release: the first accepted vector appears 4 cycles later with no garbage outputs beforehand.
- Simultaneous events: an output handshake and an input acceptance in the same cycle are both honoured.
- Datapath gating: data registers load only when advance is high and the upstream stage valid is set. Sample values on X/Z inputs do not propagate while in_valid=0.

Optional Feature:
- DCT_SAT_STATUS_EN defined:
  - Adds output port sat_flag (1 bit), asserted with out_valid when any coefficient in that vector saturated; held stable under stall.
  - Adds output port sat_count (16 bits), which increments once per output handshake whose vector saturated, wraps at 0xFFFF to 0, and resets to 0.
- Not defined: neither port exists, and no saturation-detect logic is synthesised.

Test Plan:
- DC input: all x=100, tag 3, out_ready=1.
  - Expected: exactly 4 cycles later out_valid=1, X0=283, X1..X7=0, out_tag=3.
- Impulse input: x0=64, x1..x7=0.
  - Expected: X = {23, 31, 30, 27, 23, 18, 12, 6}, each ±1 LSB.
- Saturation: all x=32767, then all x=-32768.
  - Expected: X0=32767 and X0=-32768 respectively, all other coefficients 0.
  - With DCT_SAT_STATUS_EN: sat_flag=1 for both vectors and sat_count=2.
- Back-pressure: stream 20 vectors (tags 0..15, then wrapping) with out_ready randomly low about 50% of cycles.
  - Expected: no vector lost or duplicated, order and tags preserved, out_data stable while stalled.
  - Expected: in_ready=0 only when out_valid=1 && out_ready=0.
- Full throughput: 16 back-to-back vectors with out_ready=1.
  - Expected: in_ready constant 1 and 16 consecutive out_valid cycles starting at cycle 4.
- Reset mid-stream: assert rst_n low with 3 vectors in flight.
  - Expected: out_valid=0 and out_data=0 immediately (asynchronously).
  - Expected: after release, only the newly injected vectors emerge, with 4-cycle latency.
